// File: rtl/xrs2_pkg.sv
// xrs2 shared definitions: write-size encodings and sequencer states.
// Imported by every xrs2 file.
package xrs2_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

endpackage

// File: rtl/xrs2_if.sv
// xrs2 register-file bus: write port, packed read addresses/data, busy.
// master = client (drives writes/addresses), slave = xrs2.
interface xrs2_if
    import xrs2_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NRP  = 2
);

    logic                 we_i;
    logic [AW-1:0]        rd_i;
    logic [XLEN-1:0]      rdat_i;
    logic [1:0]           wsz_i;
    logic                 wsx_i;
    logic [NRP*AW-1:0]    ra_i;
    logic [NRP*XLEN-1:0]  rdat_o;
    logic                 busy_o;

    modport master (
        output we_i, rd_i, rdat_i, wsz_i, wsx_i, ra_i,
        input  rdat_o, busy_o
    );

    modport slave (
        input  we_i, rd_i, rdat_i, wsz_i, wsx_i, ra_i,
        output rdat_o, busy_o
    );

endinterface

// File: rtl/xrs2_bank.sv
// xrs2_bank: one storage copy, one write port, one synchronous read port.
// Ports: clk_i, we_i/wa_i/wd_i (write), ra_i -> rd_o (registered read).
module xrs2_bank
    import xrs2_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [AW-1:0]   ra_i,
    output logic [XLEN-1:0] rd_o
);

    logic [XLEN-1:0] mem [2**AW];

    // Read-before-write: a colliding read returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wa_i] <= wd_i;
        end
        rd_o <= mem[ra_i];
    end

endmodule

// File: rtl/xrs2.sv
// xrs2: register file, NRP sync read ports, one extending write port,
// post-reset clear sequencer. Ports: clk_i, reset_i, bus (xrs2_if.slave).
// Optional: XRS2_BYPASS_EN enables write-through forwarding.
module xrs2
    import xrs2_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic  clk_i,
    input  logic  reset_i,
    xrs2_if.slave bus
);

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;

    // Clear sequencer: zeroes registers 1..NREG-1, one per cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;

    // Extension is done on a 64-bit working copy and then truncated,
    // so for XLEN = 32 word and full size collapse to the same value.
    logic [63:0]     src;
    logic [63:0]     ext64;
    logic [XLEN-1:0] ext;

    always_comb begin
        src   = 64'(bus.rdat_i);
        ext64 = src;
        unique case (bus.wsz_i)
            SZ_B: ext64 = {{56{bus.wsx_i & src[7]}}, src[7:0]};
            SZ_H: ext64 = {{48{bus.wsx_i & src[15]}}, src[15:0]};
            SZ_W: ext64 = {{32{bus.wsx_i & src[31]}}, src[31:0]};
            SZ_X: ext64 = src;
            default: ext64 = src;
        endcase
    end

    assign ext = ext64[XLEN-1:0];

    // Shared write port; reset cycles write nothing.
    logic            wen;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;

    always_comb begin
        wen = 1'b0;
        wa  = bus.rd_i;
        wd  = ext;
        if (!reset_i) begin
            if (state_q == CLEAR) begin
                wen = 1'b1;
                wa  = cnt_q;
                wd  = '0;
            end else begin
                wen = bus.we_i && (bus.rd_i != '0);
            end
        end
    end

`ifdef XRS2_BYPASS_EN
    logic [XLEN-1:0] wd_q;

    always_ff @(posedge clk_i) begin
        wd_q <= wd;
    end
`endif

    logic [XLEN-1:0] lane [NRP];

    for (genvar k = 0; k < NRP; k++) begin : g_lane
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] q;
        logic            zero_q;

        assign ra = bus.ra_i[k*AW +: AW];

        xrs2_bank #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_bank (
            .clk_i (clk_i),
            .we_i  (wen),
            .wa_i  (wa),
            .wd_i  (wd),
            .ra_i  (ra),
            .rd_o  (q)
        );

        // Reads sampled in reset or CLEAR are forced to zero; this also
        // covers the last clear write racing a read of the same register.
        always_ff @(posedge clk_i) begin
            zero_q <= reset_i || (state_q == CLEAR) || (ra == '0);
        end

`ifdef XRS2_BYPASS_EN
        logic fwd_q;

        always_ff @(posedge clk_i) begin
            fwd_q <= wen && (wa == ra);
        end

        assign lane[k] = zero_q ? '0 : (fwd_q ? wd_q : q);
`else
        assign lane[k] = zero_q ? '0 : q;
`endif
    end

    always_comb begin
        bus.rdat_o = '0;
        for (int k = 0; k < NRP; k++) begin
            bus.rdat_o[k*XLEN +: XLEN] = lane[k];
        end
    end

endmodule

// File: tb/tb_xrs2.sv
// tb_xrs2: scoreboard bench for xrs2 (XLEN 64, AW 5, NRP 3).
// Expected read data is queued at drive time and checked after the edge.
module tb_xrs2;

    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NRP  = 3;

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t        sb [$];
    logic [63:0] mdl [32];

    always #5 clk = ~clk;

    xrs2_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) bus ();

    xrs2 #(
        .XLEN (XLEN),
        .AW   (AW),
        .NRP  (NRP)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ext_model(input logic [63:0] d,
                                              input logic [1:0] sz,
                                              input logic sx);
        int          w;
        logic [63:0] m;
        w = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : (sz == 2'd2) ? 32 : 64;
        if (w == 64) return d;
        m = (64'd1 << w) - 64'd1;
        if (sx && d[w-1]) return d | ~m;
        return d & m;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic step(input string tag, input logic we,
                        input logic [4:0] rd, input logic [63:0] d,
                        input logic [1:0] sz, input logic sx,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2);
        logic [63:0] nv;
        logic [63:0] ev;
        logic [4:0]  ra [3];
        exp_t        e;
        ra[0] = a0;
        ra[1] = a1;
        ra[2] = a2;
        bus.we_i   = we;
        bus.rd_i   = rd;
        bus.rdat_i = d;
        bus.wsz_i  = sz;
        bus.wsx_i  = sx;
        bus.ra_i   = {a2, a1, a0};
        nv = ext_model(d, sz, sx);
        for (int k = 0; k < NRP; k++) begin
            if (ra[k] == 5'd0) ev = 64'd0;
            else ev = mdl[ra[k]];
`ifdef XRS2_BYPASS_EN
            if (we && rd != 5'd0 && rd == ra[k]) ev = nv;
`endif
            e.tag  = tag;
            e.port = k;
            e.val  = ev;
            sb.push_back(e);
        end
        if (we && rd != 5'd0) mdl[rd] = nv;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, bus.rdat_o[e.port*XLEN +: XLEN], e.val);
        end
        @(negedge clk);
    endtask

    // Reset pulse with a write in the same cycle, then count busy cycles
    // while attempting writes. stop_at > 0 leaves CLEAR early.
    task automatic clear_seq(input int stop_at, output int n);
        rst        = 1'b1;
        bus.we_i   = 1'b1;
        bus.rd_i   = 5'd3;
        bus.rdat_i = 64'd9;
        bus.wsz_i  = 2'd3;
        bus.ra_i   = {5'd3, 5'd3, 5'd3};
        @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd1);
        for (int k = 0; k < NRP; k++) begin
            check("rst_lane", bus.rdat_o[k*XLEN +: XLEN], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bus.busy_o && n < 100) begin
            if (stop_at > 0 && n == stop_at) break;
            for (int k = 0; k < NRP; k++) begin
                check("clr_lane", bus.rdat_o[k*XLEN +: XLEN], 64'd0);
            end
            bus.we_i   = 1'b1;
            bus.rd_i   = 5'($urandom_range(1, 31));
            bus.rdat_i = {$urandom, $urandom};
            n++;
            @(negedge clk);
        end
        bus.we_i = 1'b0;
    endtask

    initial begin
        int          n;
        logic [4:0]  r;
        logic [63:0] d;

        bus.we_i   = 1'b0;
        bus.rd_i   = '0;
        bus.rdat_i = '0;
        bus.wsz_i  = 2'd0;
        bus.wsx_i  = 1'b0;
        bus.ra_i   = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        @(negedge clk);

        clear_seq(0, n);
        check("clr_len", 64'(n), 64'd31);
        for (int i = 1; i < 32; i++) begin
            r = 5'(i);
            step("clr_read", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
                 r, 5'd31 - r + 5'd1, 5'd0);
        end

        step("ext_b_sx", 1'b1, 5'd5, 64'h80, 2'd0, 1'b1,
             5'd0, 5'd0, 5'd0);
        step("ext_b_sx", 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
             5'd5, 5'd0, 5'd0);
        check("ext_b_sx_val", bus.rdat_o[63:0], 64'hFFFF_FFFF_FFFF_FF80);
        step("ext_b_zx", 1'b1, 5'd5, 64'h80, 2'd0, 1'b0,
             5'd0, 5'd0, 5'd0);
        step("ext_b_zx", 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
             5'd5, 5'd0, 5'd0);
        check("ext_b_zx_val", bus.rdat_o[63:0], 64'h80);
        step("ext_h", 1'b1, 5'd6, 64'h1234_5678_9ABC_DEF0, 2'd1, 1'b1,
             5'd0, 5'd0, 5'd0);
        step("ext_w", 1'b1, 5'd8, 64'h1234_5678_9ABC_DEF0, 2'd2, 1'b1,
             5'd6, 5'd0, 5'd0);
        step("ext_wz", 1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0, 2'd2, 1'b0,
             5'd8, 5'd6, 5'd0);
        step("ext_x", 1'b1, 5'd10, 64'h8765_4321_0FED_CBA9, 2'd3, 1'b1,
             5'd9, 5'd8, 5'd6);
        step("ext_rd", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd10, 5'd9, 5'd8);

        step("r0_wr", 1'b1, 5'd0, 64'hDEAD_BEEF, 2'd3, 1'b0,
             5'd0, 5'd0, 5'd0);
        step("r0_rd", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd0, 5'd0, 5'd0);

        step("col_init", 1'b1, 5'd7, 64'd1, 2'd3, 1'b0,
             5'd0, 5'd0, 5'd0);
        step("col_same", 1'b1, 5'd7, 64'd2, 2'd3, 1'b0,
             5'd7, 5'd1, 5'd7);
        step("col_next", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd7, 5'd7, 5'd7);
        check("col_next_val", bus.rdat_o[63:0], 64'd2);

        step("mc_load", 1'b1, 5'd3, 64'd5, 2'd3, 1'b0,
             5'd0, 5'd0, 5'd0);
        step("mc_pre", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd3, 5'd0, 5'd0);
        clear_seq(10, n);
        clear_seq(0, n);
        check("mc_len", 64'(n), 64'd31);
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        step("mc_r3", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd3, 5'd3, 5'd7);

        step("mp_w1", 1'b1, 5'd1, 64'hAAAA_0000_1111_2222, 2'd3, 1'b0,
             5'd0, 5'd0, 5'd0);
        step("mp_w2", 1'b1, 5'd2, 64'h5555_3333_4444_6666, 2'd3, 1'b0,
             5'd1, 5'd0, 5'd0);
        step("mp_rd", 1'b0, 5'd0, 64'd0, 2'd3, 1'b0,
             5'd1, 5'd2, 5'd1);

        for (int i = 0; i < 200; i++) begin
            d = {$urandom, $urandom};
            step("rand", 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), d,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xrs2.md
XRS2 -- requirements
Module: xrs2

Interface
REQ-001 Parameter: XLEN, 64, register width in bits; legal values are 32 and 64.
REQ-002 Parameter: AW, 5, register address width; NREG = 2**AW registers.
REQ-003 Parameter: NRP, 2, number of read ports, from 1 to 4.
REQ-004 Port: clk_i  input  1  processor clock; all state changes on its rising edge.
REQ-005 Port: reset_i  input  1  reset, synchronous, active-high.
REQ-006 Port: we_i  input  1  write request for this cycle.
REQ-007 Port: rd_i  input  AW  destination register address.
REQ-008 Port: rdat_i  input  XLEN  write data before extension.
REQ-009 Port: wsz_i  input  2  write size: 0 = 8 bits, 1 = 16 bits, 2 = 32 bits, 3 = XLEN bits.
REQ-010 Port: wsx_i  input  1  1 = sign-extend to XLEN; 0 = zero-extend to XLEN.
REQ-011 Port: ra_i  input  NRP*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-012 Port: rdat_o  output  NRP*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-013 Port: busy_o  output  1  1 while the clear sequence is running.

Function
REQ-014 The block SHALL implement two states: CLEAR and RUN.
REQ-015 In CLEAR, the block SHALL write zero to register cnt, with cnt counting from 1 to NREG-1, one register per cycle, and SHALL ignore we_i.
REQ-016 When cnt equals NREG-1 and that write completes, the block SHALL enter RUN on the next edge; CLEAR SHALL last exactly NREG-1 cycles.
REQ-017 busy_o SHALL be 1 in CLEAR and 0 in RUN.
REQ-018 Reads SHALL be synchronous: ra_i sampled at edge N SHALL produce data on rdat_o after edge N, and that data SHALL hold until the next edge.
REQ-019 A read of address 0 SHALL return 0; address 0 SHALL never be written.
REQ-020 While busy_o is 1, every rdat_o lane SHALL read 0.
REQ-021 In RUN, when we_i is 1 and rd_i is not 0, the block SHALL store the extended value: the low 8/16/32/XLEN bits of rdat_i per wsz_i, upper bits filled with the source MSB if wsx_i = 1, else with 0.
REQ-022 When XLEN = 32, wsz_i = 2 and wsz_i = 3 SHALL behave identically, and wsx_i SHALL be ignored for both.
REQ-023 All read ports SHALL see the same storage contents; any number of ports MAY read the same address in the same cycle.
REQ-024 A read and a write to the same non-zero address in the same cycle SHALL behave as defined in REQ-028 and REQ-029.
REQ-025 No arithmetic other than the cnt increment SHALL exist; cnt SHALL be AW bits wide and SHALL not wrap.

Reset
REQ-026 On reset_i = 1 at a clock edge, the block SHALL enter CLEAR with cnt = 1 and busy_o = 1; the cycle after reset, every rdat_o lane SHALL read 0.
REQ-027 A reset asserted mid-CLEAR or in RUN SHALL restart the clear sequence from cnt = 1; a write presented in the same cycle as reset SHALL be discarded.

Configuration
REQ-028 With XRS2_BYPASS_EN defined, a same-cycle write and read to the same non-zero address SHALL return the new extended value after the edge (write-through forwarding, applied per port).
REQ-029 Without XRS2_BYPASS_EN, the same collision SHALL return the old register contents; the new value SHALL be visible on the following read.

Structure
REQ-030 Package xrs2_pkg SHALL hold the size encodings SZ_B, SZ_H, SZ_W and SZ_X, and the state enum (CLEAR, RUN).
REQ-031 Sub-module xrs2_bank SHALL hold one storage copy with one synchronous read port and one write port; xrs2 SHALL instantiate NRP copies sharing the write port.
REQ-032 The bypass compare, extension logic and CLEAR sequencer SHALL reside in xrs2.

Verification
REQ-033 Reset scenario: pulse reset_i, then count cycles -> busy_o is 1 for exactly 31 cycles (AW = 5); after that, reading registers 1-31 returns 0.
REQ-034 Extension scenario: write rdat_i = 64'h0000_0000_0000_0080 to register 5 with wsz_i = 0, wsx_i = 1 -> reading register 5 returns 64'hFFFF_FFFF_FFFF_FF80; repeating with wsx_i = 0 returns 64'h80.
REQ-035 Register 0 scenario: write 64'hDEAD_BEEF to register 0, then read it on all ports -> every port returns 0.
REQ-036 Collision scenario: register 7 holds 1; write 2 to register 7 while reading 7 on port 0 -> port 0 returns 2 with XRS2_BYPASS_EN defined, 1 without; the next read returns 2 in both builds.
REQ-037 Mid-clear reset scenario: load register 3 with 5, reset, re-assert reset at cycle 10 of CLEAR, and attempt writes during busy_o -> busy_o stays high for 31 more cycles, and register 3 reads 0 afterward.
REQ-038 Multi-port scenario: NRP = 3, read addresses 1, 2 and 1 -> all three ports return correct data in the same cycle.
